div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 SHALL have no parameters; widths are fixed (32-bit operands, 64-bit result).
REQ-002 SHALL have port clk, input, 1: the single clock, rising-edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port signedDiv_i, input, 1: 1 = signed (DIV), 0 = unsigned (DIVU).
REQ-005 SHALL have port opNum1_i, input, 32: the dividend.
REQ-006 SHALL have port opNum2_i, input, 32: the divisor.
REQ-007 SHALL have port start_i, input, 1: request a division; held high by EX until ready_o.
REQ-008 SHALL have port annul_i, input, 1: cancel the operation in progress (flush).
REQ-009 SHALL have port result_o, output, 64: {remainder[63:32], quotient[31:0]}, consumed by EX for HI/LO.
REQ-010 SHALL have port ready_o, output, 1: result_o is valid.

Function
REQ-011 SHALL implement the four-state FSM FREE, BYZERO, ON, END.
REQ-012 In FREE with start_i=1 and annul_i=0: if opNum2_i==0, SHALL go to BYZERO; otherwise SHALL go to ON.
REQ-013 On the FREE→ON transition SHALL latch the operand magnitudes (two's-complement negate when signedDiv_i=1 and the MSB is 1), signedDiv_i, and both sign bits; clear the step counter to 0; load the 65-bit work register = {32'b0, |dividend|, 1'b0}.
REQ-014 In ON, each cycle SHALL perform one restoring step:
  - trial = work[63:32] − |divisor| (33-bit).
  - If trial is negative: work <<= 1.
  - Else: work = {trial[31:0], work[31:0], 1'b1}.
  - Counter increments.
REQ-015 After the 32nd step (counter reaches 32), SHALL go to END.
REQ-016 Sign correction at END:
  - Quotient = work[31:0], negated if signed and the sign bits differ.
  - Remainder = work[64:33], negated if signed and the dividend was negative.
REQ-017 In BYZERO, SHALL go to END the next cycle with result 64'h0.
REQ-018 In END, SHALL hold ready_o=1 and result_o stable until start_i=0, then go to FREE.
REQ-019 Outside END, SHALL drive ready_o=0 and result_o=64'h0.
REQ-020 Latency: ready_o SHALL be 1 exactly 34 cycles after the accepting edge (normal) and 2 cycles after it (divide by zero).
REQ-021 annul_i=1 in ON or BYZERO SHALL return the FSM to FREE on the next edge, with no ready_o pulse.
REQ-022 annul_i=1 in FREE SHALL block acceptance of start_i.
REQ-023 start_i and operand changes while in ON SHALL be ignored; the latched operands are used.
REQ-024 Signed −2^31 / −1 SHALL give quotient 32'h80000000 and remainder 0, with no trap.

Reset
REQ-025 rst=0 SHALL, asynchronously, force:
  - state FREE,
  - counter 0,
  - work register 0,
  - ready_o=0,
  - result_o=64'h0,
  including mid-operation.
REQ-026 After rst is released, SHALL accept a new start_i on the first clock edge.

Structure
REQ-027 The state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/DivResultNotReady, DivStart/DivStop, DoubleRegBus (63:0), and ZeroWord SHALL live in the shared defines package.
REQ-028 SHALL be a single module with no sub-modules; the trial subtraction is an inline 33-bit subtract.

Verification
REQ-029 Unsigned: opNum1=32'hFFFFFFFF, opNum2=32'h10, signedDiv_i=0 -> ready_o at cycle 34, result_o={32'h0000000F, 32'h0FFFFFFF}.
REQ-030 Signed: −7/2 -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF; 7/−2 -> quotient 32'hFFFFFFFD, remainder 32'h1.
REQ-031 Divide by zero: opNum2=0 -> ready_o at cycle 2, result_o=64'h0; ready_o stays high until start_i drops, then the FSM is in FREE.
REQ-032 Annul at step 10 -> ready_o never rises; a new start_i next cycle with 100/7 -> quotient 14, remainder 2, at 34 cycles.
REQ-033 rst pulsed low at step 20 -> outputs 0 immediately; after release, 32'h80000000 / 32'hFFFFFFFF signed -> quotient 32'h80000000, remainder 0.
REQ-034 Operands changed during ON -> the result reflects the latched operands.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings,
// handshake level names, bus types and a small magnitude helper.
package div_pkg;

   // Divider FSM states
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   typedef logic [63:0] DoubleRegBus;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // Two's-complement magnitude of v when it is a negative signed operand
   function automatic logic [31:0] abs_if_signed(input logic is_signed,
                                                 input logic [31:0] v);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

   // Conditional two's-complement negate
   function automatic logic [31:0] neg_if(input logic do_neg,
                                          input logic [31:0] v);
      return do_neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_if.sv
// Handshake bundle between the EX stage (master) and the divider (slave).
interface div_if;
   import div_pkg::*;

   logic        signed_div;
   logic [31:0] op_num1;
   logic [31:0] op_num2;
   logic        start;
   logic        annul;
   DoubleRegBus result;
   logic        ready;

   modport master (
      output signed_div, op_num1, op_num2, start, annul,
      input  result, ready
   );

   modport slave (
      input  signed_div, op_num1, op_num2, start, annul,
      output result, ready
   );

endinterface

// File: rtl/div.sv
// 32-bit restoring divider, one quotient bit per cycle, signed or unsigned.
// Result is {remainder, quotient}; held with ready_o until start_i drops.
module div
   import div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signedDiv_i,
   input  logic [31:0] opNum1_i,
   input  logic [31:0] opNum2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output DoubleRegBus result_o,
   output logic        ready_o
);

   div_state_e  state_q,   state_d;
   logic [5:0]  cnt_q,     cnt_d;
   logic [64:0] work_q,    work_d;
   logic [31:0] divisor_q, divisor_d;
   logic        signed_q,  signed_d;
   logic        sign1_q,   sign1_d;
   logic        sign2_q,   sign2_d;
   logic        ready_q,   ready_d;
   DoubleRegBus result_q,  result_d;

   logic [32:0] trial;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   assign trial    = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
   assign quot_fix = neg_if(signed_q && (sign1_q ^ sign2_q), work_q[31:0]);
   assign rem_fix  = neg_if(signed_q && sign1_q, work_q[64:33]);

   // Next-state, datapath step and registered output computation
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      signed_d  = signed_q;
      sign1_d   = sign1_q;
      sign2_d   = sign2_q;
      ready_d   = DivResultNotReady;
      result_d  = {ZeroWord, ZeroWord};

      unique case (state_q)
         DivFree: begin
            if (start_i == DivStart && !annul_i) begin
               if (opNum2_i == ZeroWord) begin
                  state_d = DivByZero;
               end else begin
                  state_d   = DivOn;
                  cnt_d     = 6'd0;
                  signed_d  = signedDiv_i;
                  sign1_d   = opNum1_i[31];
                  sign2_d   = opNum2_i[31];
                  divisor_d = abs_if_signed(signedDiv_i, opNum2_i);
                  work_d    = {ZeroWord, abs_if_signed(signedDiv_i, opNum1_i), 1'b0};
               end
            end
         end

         DivByZero: begin
            // Result stays zero; the END state publishes it
            work_d  = '0;
            state_d = annul_i ? DivFree : DivEnd;
         end

         DivOn: begin
            if (annul_i) begin
               state_d = DivFree;
            end else if (cnt_q != 6'd32) begin
               if (trial[32]) begin
                  work_d = {work_q[63:0], 1'b0};
               end else begin
                  work_d = {trial[31:0], work_q[31:0], 1'b1};
               end
               cnt_d = cnt_q + 6'd1;
            end else begin
               state_d = DivEnd;
               cnt_d   = 6'd0;
            end
         end

         DivEnd: begin
            // Hold the answer until EX releases start
            if (start_i == DivStop) begin
               state_d = DivFree;
            end else begin
               ready_d  = DivResultReady;
               result_d = {rem_fix, quot_fix};
            end
         end

         default: state_d = DivFree;
      endcase
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= DivFree;
         cnt_q     <= 6'd0;
         work_q    <= '0;
         divisor_q <= ZeroWord;
         signed_q  <= 1'b0;
         sign1_q   <= 1'b0;
         sign2_q   <= 1'b0;
         ready_q   <= DivResultNotReady;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         signed_q  <= signed_d;
         sign1_q   <= sign1_d;
         sign2_q   <= sign2_d;
         ready_q   <= ready_d;
         result_q  <= result_d;
      end
   end

   assign ready_o  = ready_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_div.sv
// Randomised self-checking bench for the divider against an arithmetic model.
module tb_div;
   import div_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   div_if bus ();

   div dut (
      .clk         (clk),
      .rst         (rst),
      .signedDiv_i (bus.signed_div),
      .opNum1_i    (bus.op_num1),
      .opNum2_i    (bus.op_num2),
      .start_i     (bus.start),
      .annul_i     (bus.annul),
      .result_o    (bus.result),
      .ready_o     (bus.ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison, report it if it disagrees
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division, truncating toward zero
   function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, sq, sr;
      logic [31:0] uq, ur;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         sq = sa / sb;
         sr = sa % sb;
         return {sr[31:0], sq[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   // One complete division transaction with latency, hold and release checks
   task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input bit pulse_rst);
      logic [63:0] exp;
      int          exp_lat;
      int          cyc;
      bit          got_ready;
      exp     = ref_div(s, a, b);
      exp_lat = (b == 32'd0) ? 2 : 34;
      @(negedge clk);
      bus.signed_div = s;
      bus.op_num1    = a;
      bus.op_num2    = b;
      bus.annul      = 1'b0;
      bus.start      = 1'b1;
      @(posedge clk);
      cyc       = 0;
      got_ready = 0;
      while (!got_ready && cyc < 80) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.ready) got_ready = 1;
         else if (cyc == 1) check("idle_result", bus.result, 64'd0);
         if (scramble && cyc == 3) begin
            bus.op_num1    = $urandom;
            bus.op_num2    = $urandom;
            bus.signed_div = ~s;
         end
      end
      check("latency", 64'(cyc), 64'(exp_lat));
      check("result", bus.result, exp);
      $display("div s=%0d a=%h b=%h -> %h (exp %h) lat=%0d", s, a, b, bus.result, exp, cyc);
      @(posedge clk);
      #1;
      check("hold_ready", {63'd0, bus.ready}, 64'd1);
      check("hold_result", bus.result, exp);
      if (pulse_rst) begin
         #2 rst = 1'b0;
         #1;
         check("async_ready", {63'd0, bus.ready}, 64'd0);
         check("async_result", bus.result, 64'd0);
         @(negedge clk);
         bus.start = 1'b0;
         rst       = 1'b1;
      end else begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      check("drop_ready", {63'd0, bus.ready}, 64'd0);
      check("drop_result", bus.result, 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit          rs;
      bit          seen;
      n_cmp = 0;
      n_bad = 0;
      rst            = 1'b0;
      bus.signed_div = 1'b0;
      bus.op_num1    = 32'd0;
      bus.op_num2    = 32'd0;
      bus.start      = 1'b0;
      bus.annul      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {63'd0, bus.ready}, 64'd0);
      check("rst_result", bus.result, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Directed cases
      run_div(0, 32'hFFFF_FFFF, 32'h0000_0010, 0, 0);
      run_div(1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
      run_div(1, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0);
      run_div(1, 32'h0000_0005, 32'h0000_0000, 0, 0);
      run_div(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_div(0, 32'h1234_5678, 32'h0000_0123, 1, 0);
      run_div(1, 32'h8765_4321, 32'h0000_0045, 0, 1);

      // Annul at step 10, then an immediate fresh request
      @(negedge clk);
      bus.signed_div = 1'b0;
      bus.op_num1    = 32'd1000;
      bus.op_num2    = 32'd3;
      bus.start      = 1'b1;
      @(posedge clk);
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.ready) seen = 1;
      end
      @(negedge clk);
      bus.annul = 1'b1;
      bus.start = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.ready) seen = 1;
         bus.annul = 1'b0;
      end
      check("annul_no_ready", {63'd0, seen}, 64'd0);
      run_div(0, 32'd100, 32'd7, 0, 0);

      // Annul held in FREE must keep a start from being accepted
      @(negedge clk);
      bus.annul   = 1'b1;
      bus.start   = 1'b1;
      bus.op_num1 = 32'd55;
      bus.op_num2 = 32'd5;
      repeat (6) @(posedge clk);
      run_div(0, 32'd55, 32'd5, 0, 0);

      // Reset pulsed mid-operation at step 20
      @(negedge clk);
      bus.signed_div = 1'b0;
      bus.op_num1    = 32'hDEAD_BEEF;
      bus.op_num2    = 32'd9;
      bus.start      = 1'b1;
      @(posedge clk);
      repeat (20) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midop_rst_ready", {63'd0, bus.ready}, 64'd0);
      check("midop_rst_result", bus.result, 64'd0);
      bus.start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      run_div(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if (i % 13 == 5) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         run_div(rs, ra, rb, (i % 7) == 3, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
